// File: rtl/axi4_lite_ram_slave.sv
// AXI4-Lite slave backed by a single-port RAM: one-entry AW/W/AR holding registers,
// byte-strobe writes, DECERR outside the address window, round-robin RAM port sharing.
module axi4_lite_ram_slave #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 32,
   parameter int unsigned           STRB_WIDTH     = DATA_WIDTH / 8,
   parameter int unsigned           MEM_DEPTH_LOG2 = 6,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   input  logic [DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [STRB_WIDTH-1:0] S_AXI_WSTRB,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,
   output logic [1:0]            S_AXI_BRESP,
   input  logic                  S_AXI_ARVALID,
   output logic                  S_AXI_ARREADY,
   input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
   output logic                  S_AXI_RVALID,
   input  logic                  S_AXI_RREADY,
   output logic [DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]            S_AXI_RRESP
);

   localparam int unsigned           BYTE_LSB  = $clog2(STRB_WIDTH);
   localparam int unsigned           MEM_DEPTH = 2 ** MEM_DEPTH_LOG2;
   localparam logic [ADDR_WIDTH:0]   WIN_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_WIDTH);
   localparam logic [1:0]            RESP_OKAY   = 2'b00;
   localparam logic [1:0]            RESP_DECERR = 2'b11;

   typedef enum logic {GRANT_WRITE, GRANT_READ} grant_e;
   typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  aw_full_q, aw_full_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_full_q, w_full_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic                  ar_full_q, ar_full_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   grant_e                last_grant_q, last_grant_d;

   logic aw_hs, w_hs, ar_hs;
   logic wr_req, rd_req, grant_wr, grant_rd;

   // The extra top bit of each difference is the borrow: set when addr < BASE_ADDR.
   logic [ADDR_WIDTH:0] aw_diff, ar_diff;
   logic                aw_hit, ar_hit;
   idx_t                aw_idx, ar_idx;
   logic                unused_addr_bits;

   assign aw_diff = {1'b0, aw_addr_q} - {1'b0, BASE_ADDR};
   assign ar_diff = {1'b0, ar_addr_q} - {1'b0, BASE_ADDR};
   assign aw_hit  = !aw_diff[ADDR_WIDTH] && ({1'b0, aw_diff[ADDR_WIDTH-1:0]} < WIN_BYTES);
   assign ar_hit  = !ar_diff[ADDR_WIDTH] && ({1'b0, ar_diff[ADDR_WIDTH-1:0]} < WIN_BYTES);
   assign aw_idx  = aw_diff[BYTE_LSB +: MEM_DEPTH_LOG2];
   assign ar_idx  = ar_diff[BYTE_LSB +: MEM_DEPTH_LOG2];
   assign unused_addr_bits = ^{aw_diff, ar_diff};

   assign S_AXI_AWREADY = !aw_full_q && !ARESET;
   assign S_AXI_WREADY  = !w_full_q && !ARESET;
   assign S_AXI_ARREADY = !ar_full_q && !ARESET;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // A request only competes when its response slot is free or being drained this edge.
   assign wr_req   = aw_full_q && w_full_q && (!bvalid_q || S_AXI_BREADY);
   assign rd_req   = ar_full_q && (!rvalid_q || S_AXI_RREADY);
   assign grant_rd = rd_req && (!wr_req || (last_grant_q == GRANT_WRITE));
   assign grant_wr = wr_req && !grant_rd;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      aw_full_d    = aw_full_q;
      aw_addr_d    = aw_addr_q;
      w_full_d     = w_full_q;
      w_data_d     = w_data_q;
      w_strb_d     = w_strb_q;
      ar_full_d    = ar_full_q;
      ar_addr_d    = ar_addr_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;
      last_grant_d = last_grant_q;

      if (aw_hs) begin
         aw_full_d = 1'b1;
         aw_addr_d = S_AXI_AWADDR;
      end else if (grant_wr) begin
         aw_full_d = 1'b0;
      end

      if (w_hs) begin
         w_full_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end else if (grant_wr) begin
         w_full_d = 1'b0;
      end

      if (ar_hs) begin
         ar_full_d = 1'b1;
         ar_addr_d = S_AXI_ARADDR;
      end else if (grant_rd) begin
         ar_full_d = 1'b0;
      end

      if (grant_wr) begin
         bvalid_d     = 1'b1;
         bresp_d      = aw_hit ? RESP_OKAY : RESP_DECERR;
         last_grant_d = GRANT_WRITE;
      end else if (S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      if (grant_rd) begin
         rvalid_d     = 1'b1;
         rresp_d      = ar_hit ? RESP_OKAY : RESP_DECERR;
         rdata_d      = ar_hit ? mem[ar_idx] : '0;
         last_grant_d = GRANT_READ;
      end else if (S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_full_q    <= 1'b0;
         aw_addr_q    <= '0;
         w_full_q     <= 1'b0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         ar_full_q    <= 1'b0;
         ar_addr_q    <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= RESP_OKAY;
         rvalid_q     <= 1'b0;
         rresp_q      <= RESP_OKAY;
         rdata_q      <= '0;
         last_grant_q <= GRANT_WRITE;
      end else begin
         aw_full_q    <= aw_full_d;
         aw_addr_q    <= aw_addr_d;
         w_full_q     <= w_full_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         ar_full_q    <= ar_full_d;
         ar_addr_q    <= ar_addr_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
         last_grant_q <= last_grant_d;
      end
   end

   // NOTE: the RAM array has no reset; contents survive ARESET, only the write is gated by it.
   always_ff @(posedge ACLK) begin
      if (!ARESET && grant_wr && aw_hit) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_strb_q[i]) mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
         end
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;

endmodule

// File: tb/tb_axi4_lite_ram_slave.sv
// Directed bench for axi4_lite_ram_slave: one instance at BASE_ADDR=0, a second at 0x1000
// sharing the same stimulus so window decode can be checked against both.
module tb_axi4_lite_ram_slave;

   logic        ACLK;
   logic        ARESET;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;

   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        awready1, wready1, bvalid1, arready1, rvalid1;
   logic [1:0]  bresp1, rresp1;
   logic [31:0] rdata1;

   int checks = 0;
   int errors = 0;

   logic [1:0]  r0, r1;
   logic [31:0] d0, d1;
   int          lat;

   axi4_lite_ram_slave dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp)
   );

   axi4_lite_ram_slave #(.BASE_ADDR(32'h0000_1000)) dut_hi (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready1), .S_AXI_AWADDR(awaddr),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready1), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp1),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready1), .S_AXI_ARADDR(araddr),
      .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // Drives AW and W together, returns when BVALID is seen; lat counts cycles from the handshake.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp0, output logic [1:0] resp1, output int lt);
      bit aw_go, w_go;
      int guard = 0;
      @(negedge ACLK);
      awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
      while ((awvalid || wvalid) && guard < 50) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(negedge ACLK);
         if (aw_go) awvalid = 1'b0;
         if (w_go) wvalid = 1'b0;
         guard++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      lt = 1;
      while (!bvalid && lt < 50) begin
         @(negedge ACLK);
         lt++;
      end
      resp0 = bresp; resp1 = bresp1;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data0, output logic [1:0] resp0,
                           output logic [31:0] data1, output logic [1:0] resp1, output int lt);
      bit ar_go;
      int guard = 0;
      @(negedge ACLK);
      arvalid = 1'b1; araddr = addr;
      while (arvalid && guard < 50) begin
         ar_go = arready;
         @(negedge ACLK);
         if (ar_go) arvalid = 1'b0;
         guard++;
      end
      arvalid = 1'b0;
      lt = 1;
      while (!rvalid && lt < 50) begin
         @(negedge ACLK);
         lt++;
      end
      data0 = rdata; resp0 = rresp; data1 = rdata1; resp1 = rresp1;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      repeat (2) @(negedge ACLK);
      checks++; if ({awready, wready, arready} !== 3'b000) begin errors++;
         $display("FAIL reset_ready: got %b expected 000", {awready, wready, arready}); end
      checks++; if ({bvalid, rvalid} !== 2'b00) begin errors++;
         $display("FAIL reset_valid: got %b expected 00", {bvalid, rvalid}); end
      checks++; if ({bresp, rresp, rdata} !== 36'h0) begin errors++;
         $display("FAIL reset_resp_data: got bresp=%b rresp=%b rdata=%h expected 0", bresp, rresp, rdata); end
      ARESET = 1'b0;
      @(negedge ACLK);
      checks++; if ({awready, wready, arready} !== 3'b111) begin errors++;
         $display("FAIL ready_after_reset: got %b expected 111", {awready, wready, arready}); end
   endtask

   task automatic test_single();
      axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, r0, r1, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
      checks++; if (r0 !== 2'b00) begin errors++; $display("FAIL write_bresp: got %b expected 00", r0); end
      axi_read(32'h04, d0, r0, d1, r1, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
      checks++; if (d0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_0x04: got %h expected deadbeef", d0); end
      checks++; if (r0 !== 2'b00) begin errors++; $display("FAIL read_rresp: got %b expected 00", r0); end
   endtask

   task automatic test_w_first();
      bit early_b = 1'b0;
      @(negedge ACLK);
      wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'hF;
      @(negedge ACLK);
      wvalid = 1'b0;
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wready_held: got %b expected 0", wready); end
      repeat (3) begin
         @(negedge ACLK);
         if (bvalid) early_b = 1'b1;
      end
      checks++; if (early_b !== 1'b0) begin errors++; $display("FAIL bvalid_before_aw: got 1 expected 0"); end
      awvalid = 1'b1; awaddr = 32'h08;
      @(negedge ACLK);
      awvalid = 1'b0;
      lat = 1;
      while (!bvalid && lat < 50) begin @(negedge ACLK); lat++; end
      checks++; if (lat !== 2 || bresp !== 2'b00) begin errors++;
         $display("FAIL w_first_resp: got lat=%0d bresp=%b expected lat=2 bresp=00", lat, bresp); end
      axi_read(32'h08, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'h1122_3344) begin errors++; $display("FAIL read_0x08: got %h expected 11223344", d0); end
   endtask

   task automatic test_strobes();
      axi_write(32'h0C, 32'hFFFF_FFFF, 4'hF, r0, r1, lat);
      axi_write(32'h0C, 32'h00AA_0000, 4'h4, r0, r1, lat);
      axi_read(32'h0C, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'hFFAA_FFFF) begin errors++; $display("FAIL strobe_byte2: got %h expected ffaaffff", d0); end
      axi_write(32'h0C, 32'h1234_5678, 4'h0, r0, r1, lat);
      checks++; if (r0 !== 2'b00) begin errors++; $display("FAIL strobe_zero_bresp: got %b expected 00", r0); end
      axi_read(32'h0C, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'hFFAA_FFFF) begin errors++; $display("FAIL strobe_zero_data: got %h expected ffaaffff", d0); end
   endtask

   task automatic test_out_of_range();
      axi_write(32'h00, 32'h0000_CAFE, 4'hF, r0, r1, lat);
      axi_write(32'h100, 32'h1234_5678, 4'hF, r0, r1, lat);
      checks++; if (r0 !== 2'b11 || lat !== 2) begin errors++;
         $display("FAIL oor_write: got bresp=%b lat=%0d expected 11 2", r0, lat); end
      axi_read(32'h100, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'h0 || r0 !== 2'b11) begin errors++;
         $display("FAIL oor_read: got %h/%b expected 00000000/11", d0, r0); end
      axi_read(32'h00, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'h0000_CAFE) begin errors++; $display("FAIL oor_no_wrap: got %h expected 0000cafe", d0); end
      axi_write(32'hFC, 32'h0F0F_0F0F, 4'hF, r0, r1, lat);
      checks++; if (r0 !== 2'b00) begin errors++; $display("FAIL last_word_bresp: got %b expected 00", r0); end
      axi_read(32'hFC, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'h0F0F_0F0F || r0 !== 2'b00) begin errors++;
         $display("FAIL last_word_read: got %h/%b expected 0f0f0f0f/00", d0, r0); end
      axi_write(32'h0FFC, 32'h7777_7777, 4'hF, r0, r1, lat);
      checks++; if (r1 !== 2'b11) begin errors++; $display("FAIL base_below_write: got %b expected 11", r1); end
      axi_read(32'h0FFC, d0, r0, d1, r1, lat);
      checks++; if (d1 !== 32'h0 || r1 !== 2'b11) begin errors++;
         $display("FAIL base_below_read: got %h/%b expected 00000000/11", d1, r1); end
      axi_write(32'h1004, 32'h600D_CAFE, 4'hF, r0, r1, lat);
      checks++; if (r1 !== 2'b00 || r0 !== 2'b11) begin errors++;
         $display("FAIL base_in_write: got hi=%b lo=%b expected 00 11", r1, r0); end
      axi_read(32'h1004, d0, r0, d1, r1, lat);
      checks++; if (d1 !== 32'h600D_CAFE || r1 !== 2'b00) begin errors++;
         $display("FAIL base_in_read: got %h/%b expected 600dcafe/00", d1, r1); end
   endtask

   task automatic test_contention();
      logic [7:0]  ev[$];
      logic [31:0] rd_seen[$];
      logic [7:0]  exp_ev;
      logic [31:0] exp_d, got_d;
      int          bad_resp = 0;
      ARESET = 1'b1;
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      fork
         begin
            int k = 0;
            int g = 0;
            bit go;
            awaddr = 32'h20; wdata = 32'hC0DE_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
            while (k < 8 && g < 100) begin
               go = awready && wready;
               @(negedge ACLK);
               g++;
               if (go) begin
                  k++;
                  if (k < 8) begin
                     awaddr = 32'h20 + 32'(4 * k);
                     wdata  = 32'hC0DE_0000 + 32'(k);
                  end else begin
                     awvalid = 1'b0; wvalid = 1'b0;
                  end
               end
            end
         end
         begin
            int k = 0;
            int g = 0;
            bit go;
            araddr = 32'h04; arvalid = 1'b1;
            while (k < 8 && g < 100) begin
               go = arready;
               @(negedge ACLK);
               g++;
               if (go) begin
                  k++;
                  if (k < 8) araddr = 32'h20 + 32'(4 * (k - 1));
                  else arvalid = 1'b0;
               end
            end
         end
         begin
            repeat (40) begin
               @(negedge ACLK);
               if (bvalid && rvalid) ev.push_back("B");
               else if (bvalid) ev.push_back("W");
               else if (rvalid) ev.push_back("R");
               if (bvalid && bresp !== 2'b00) bad_resp++;
               if (rvalid) begin
                  rd_seen.push_back(rdata);
                  if (rresp !== 2'b00) bad_resp++;
               end
            end
         end
      join
      checks++; if (ev.size() != 16) begin errors++; $display("FAIL contention_count: got %0d expected 16", ev.size()); end
      for (int i = 0; i < 16; i++) begin
         exp_ev = (i % 2 == 0) ? "R" : "W";
         checks++; if (i >= ev.size() || ev[i] !== exp_ev) begin errors++;
            $display("FAIL grant_order[%0d]: got %c expected %c", i, (i < ev.size()) ? ev[i] : "-", exp_ev); end
      end
      for (int i = 0; i < 8; i++) begin
         exp_d = (i == 0) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + 32'(i - 1);
         got_d = (i < rd_seen.size()) ? rd_seen[i] : 32'hxxxx_xxxx;
         checks++; if (got_d !== exp_d) begin errors++;
            $display("FAIL contention_rdata[%0d]: got %h expected %h", i, got_d, exp_d); end
      end
      checks++; if (bad_resp != 0) begin errors++; $display("FAIL contention_resp: got %0d errors expected 0", bad_resp); end
   endtask

   task automatic test_backpressure_reset();
      rready = 1'b0;
      axi_read(32'h08, d0, r0, d1, r1, lat);
      arvalid = 1'b1; araddr = 32'h0C;
      @(negedge ACLK);
      arvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (rvalid !== 1'b1 || rdata !== 32'h1122_3344 || arready !== 1'b0) begin errors++;
            $display("FAIL backpressure[%0d]: got rvalid=%b rdata=%h arready=%b expected 1 11223344 0",
                     i, rvalid, rdata, arready); end
         @(negedge ACLK);
      end
      rready = 1'b1;
      @(negedge ACLK);
      checks++; if (rvalid !== 1'b1 || rdata !== 32'hFFAA_FFFF) begin errors++;
         $display("FAIL queued_read: got rvalid=%b rdata=%h expected 1 ffaaffff", rvalid, rdata); end
      @(negedge ACLK);
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drain: got %b expected 0", rvalid); end

      axi_write(32'h10, 32'hA5A5_A5A5, 4'hF, r0, r1, lat);
      rready = 1'b0;
      axi_read(32'h08, d0, r0, d1, r1, lat);
      @(negedge ACLK);
      awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
      @(negedge ACLK);
      awvalid = 1'b0; wvalid = 1'b0;
      ARESET = 1'b1;
      @(negedge ACLK);
      checks++; if ({bvalid, rvalid, awready} !== 3'b000 || rdata !== 32'h0) begin errors++;
         $display("FAIL mid_reset: got bvalid=%b rvalid=%b awready=%b rdata=%h expected 0 0 0 0",
                  bvalid, rvalid, awready, rdata); end
      ARESET = 1'b0;
      rready = 1'b1;
      axi_read(32'h10, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'hA5A5_A5A5 || lat !== 2) begin errors++;
         $display("FAIL no_stray_write: got %h lat=%0d expected a5a5a5a5 2", d0, lat); end
      axi_write(32'h10, 32'h5555_5555, 4'hF, r0, r1, lat);
      checks++; if (r0 !== 2'b00 || lat !== 2) begin errors++;
         $display("FAIL post_reset_write: got %b lat=%0d expected 00 2", r0, lat); end
      axi_read(32'h10, d0, r0, d1, r1, lat);
      checks++; if (d0 !== 32'h5555_5555) begin errors++; $display("FAIL post_reset_read: got %h expected 55555555", d0); end
   endtask

   initial begin
      ARESET = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      bready = 1'b1; rready = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      test_reset();
      test_single();
      test_w_first();
      test_strobes();
      test_out_of_range();
      test_contention();
      test_backpressure_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
